seg_fsm_monitor: RTL

//  Receive-side checker for the x/y-driven 4-state FSM that publishes its state on segments {a,b,c,d,e,f,g}.

---
 rtl/seg_fsm_monitor.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg_fsm_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : seg_fsm_monitor
//  Purpose  : Receive-side checker for a 4-state x/y-driven FSM that shows
//             its state on active-low segments {a,b,c,d,e,f,g}. It decodes
//             each step's pattern, checks it against the transition table
//             and the sticky z rule, and counts errors.
//  Revision : 1.0  initial release
// ============================================================================
module seg_fsm_monitor #(
  parameter int SETTLE_CYC  = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fsm_clock,
  input  logic             x,
  input  logic             y,
  input  logic [6:0]       seg,
  input  logic             z,
  output logic [1:0]       state_q,
  output logic             state_valid,
  output logic             step_done,
  output logic             mismatch,
  output logic             invalid_pat,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  localparam int         c_in_w        = 11;
  localparam logic [7:0] c_settle_last = 8'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_in_w-1:0] r_sync [SYNC_STAGES];
  logic              r_fclk_d;
  logic [1:0]        r_xy;
  logic [1:0]        r_prev;
  logic              r_seed;
  logic              r_overrun;
  logic              r_exp_z;
  logic [7:0]        r_settle_cnt;

  logic [c_in_w-1:0] w_in;
  logic              w_fclk;
  logic              w_x;
  logic              w_y;
  logic [6:0]        w_seg;
  logic              w_z;
  logic              w_edge;
  logic              w_pat_ok;
  logic [1:0]        w_dec;
  logic [1:0]        w_exp_state;
  logic              w_z_set;
  logic              w_exp_z_upd;
  logic              w_cmp_bad;
  logic              w_done;
  logic              w_mm_pulse;
  logic              w_inv_pulse;
  logic              w_ovr_err;
  logic [1:0]        w_inc;
  logic [CNT_W:0]    w_sum;

  // Bring every FSM-side signal into the clk domain through the same chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= {fsm_clock, x, y, seg, z};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_in   = r_sync[SYNC_STAGES-1];
  assign w_fclk = w_in[10];
  assign w_x    = w_in[9];
  assign w_y    = w_in[8];
  assign w_seg  = w_in[7:1];
  assign w_z    = w_in[0];
  assign w_edge = w_fclk & ~r_fclk_d;

  // Map the segment pattern back to a state number
  always_comb begin
    w_pat_ok = 1'b1;
    w_dec    = 2'd0;
    case (w_seg)
      7'b0000001: w_dec = 2'd0;
      7'b1001111: w_dec = 2'd1;
      7'b0010010: w_dec = 2'd2;
      7'b0000110: w_dec = 2'd3;
      default:    w_pat_ok = 1'b0;
    endcase
  end

  // Reference transition table and sticky z rule
  always_comb begin
    w_exp_state = 2'd0;
    case ({r_prev, r_xy})
      4'b00_00: w_exp_state = 2'd2;
      4'b00_01: w_exp_state = 2'd0;
      4'b00_10: w_exp_state = 2'd3;
      4'b00_11: w_exp_state = 2'd1;
      4'b01_00: w_exp_state = 2'd1;
      4'b01_01: w_exp_state = 2'd1;
      4'b01_10: w_exp_state = 2'd2;
      4'b01_11: w_exp_state = 2'd3;
      4'b10_00: w_exp_state = 2'd2;
      4'b10_01: w_exp_state = 2'd2;
      4'b10_10: w_exp_state = 2'd0;
      4'b10_11: w_exp_state = 2'd2;
      4'b11_00: w_exp_state = 2'd3;
      4'b11_01: w_exp_state = 2'd2;
      4'b11_10: w_exp_state = 2'd2;
      default:  w_exp_state = 2'd3;
    endcase
    w_z_set     = ((r_prev == 2'd1) && (r_xy == 2'b00)) ||
                  ((r_prev == 2'd3) && ((r_xy == 2'b00) || (r_xy == 2'b11)));
    w_exp_z_upd = r_exp_z | w_z_set;
    w_cmp_bad   = (w_dec != w_exp_state) || (w_z != w_exp_z_upd);
  end

  // Monitor state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_SYNC;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-cycle event pulses
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_mm_pulse  = 1'b0;
    w_inv_pulse = 1'b0;
    w_ovr_err   = 1'b0;
    case (r_state)
      ST_SYNC, ST_IDLE: begin
        if (w_edge) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        w_ovr_err = w_edge;
        if (r_settle_cnt == c_settle_last) w_state_nxt = ST_CHECK;
      end
      default: begin
        w_ovr_err = w_edge;
        w_done    = 1'b1;
        if (!w_pat_ok) begin
          w_inv_pulse = 1'b1;
        end else if (!r_seed) begin
          w_mm_pulse = w_cmp_bad;
        end
        // A step that arrived mid-check breaks the step chain: resync
        if (!w_pat_ok || r_overrun || w_edge) w_state_nxt = ST_SYNC;
        else                                 w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_inc = 2'(w_mm_pulse) + 2'(w_inv_pulse) + 2'(w_ovr_err);
  assign w_sum = {1'b0, err_count} + {{(CNT_W-1){1'b0}}, w_inc};

  // Step context, decoded state, expected z and error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fclk_d     <= 1'b0;
      r_xy         <= 2'b00;
      r_prev       <= 2'd0;
      r_seed       <= 1'b0;
      r_overrun    <= 1'b0;
      r_exp_z      <= 1'b0;
      r_settle_cnt <= 8'd0;
      state_q      <= 2'd0;
      state_valid  <= 1'b0;
      step_done    <= 1'b0;
      mismatch     <= 1'b0;
      invalid_pat  <= 1'b0;
      err_sticky   <= 1'b0;
      err_count    <= '0;
    end else begin
      r_fclk_d    <= w_fclk;
      step_done   <= w_done;
      mismatch    <= w_mm_pulse;
      invalid_pat <= w_inv_pulse;

      if (((r_state == ST_SYNC) || (r_state == ST_IDLE)) && w_edge) begin
        r_xy         <= {w_x, w_y};
        r_prev       <= state_q;
        r_seed       <= (r_state == ST_SYNC);
        r_overrun    <= 1'b0;
        r_settle_cnt <= 8'd0;
      end
      if (r_state == ST_SETTLE) r_settle_cnt <= r_settle_cnt + 8'd1;
      if (w_ovr_err) r_overrun <= 1'b1;

      if (r_state == ST_CHECK) begin
        if (!w_pat_ok) begin
          state_valid <= 1'b0;
        end else if (r_seed) begin
          state_q     <= w_dec;
          state_valid <= 1'b1;
          r_exp_z     <= w_z;
        end else begin
          state_q     <= w_dec;
          state_valid <= 1'b1;
          r_exp_z     <= w_cmp_bad ? w_z : w_exp_z_upd;
        end
      end

      if (w_inc != 2'd0) err_sticky <= 1'b1;
      if (w_sum[CNT_W]) err_count <= '1;
      else              err_count <= w_sum[CNT_W-1:0];
    end
  end

endmodule
`default_nettype wire
